text_scanout: RTL and testbench
===============================

// Module: text_scanout
// PURPOSE
// - Read side of the text video RAM written by the console block: for each VGA pixel, fetch the
//   character code from VRAM, look up its glyph in the font ROM, and emit the pixel colour.
// - Sits between the VGA sync generator (pixel coordinates, syncs) and the RGB pins.
// - Fixed 3-stage pipeline; hsync/vsync/active are delayed to stay aligned with the pixel.
// PARAMETERS
// - size  16     cell size in pixels, square, power of 2, 8..256; glyph scale = size/8
// - FG    3'b111 foreground RGB
// - BG    3'b000 background RGB
// PORTS
// - clk        in   1   pixel clock, single clock domain
// - reset      in   1   synchronous, active-high
// - px_x       in   10  current pixel column, 0..799
// - px_y       in   10  current pixel row, 0..524
// - active_i   in   1   visible area flag from the sync generator
// - hsync_i    in   1   horizontal sync, passed through
// - vsync_i    in   1   vertical sync, passed through
// - cursor_x   in   7   cursor column (console side)
// - cursor_y   in   7   cursor row (console side)
// - vram_rd    out  1   VRAM read enable
// - vram_addr  out  13  VRAM read address
// - vram_data  in   8   character code; valid 1 clk after vram_rd
// - font_addr  out  11  {char[7:0], glyph_row[2:0]}
// - font_data  in   8   glyph row bits, bit7 = leftmost; valid 1 clk after font_addr
// - rgb        out  3   pixel colour
// - hsync_o    out  1   hsync_i delayed 3 clk
// - vsync_o    out  1   vsync_i delayed 3 clk
// - active_o   out  1   active_i delayed 3 clk
// BEHAVIOUR
// - Geometry: cols = 640/size; rows_max = fin_pag+1 (size 8:52, 16:31, 32:16, 64:8, 128:4, 256:2).
// - Cell: col = px_x/size, row = px_y/size (shifts). Glyph row = (px_y%size)/(size/8).
//   Glyph bit = 7-((px_x%size)/(size/8)).
// - S0 (edge 1):
//   - vram_addr <= row*cols+col, 13-bit truncated.
//   - vram_rd <= active_i && px_x<640 && row<rows_max.
//   - Capture glyph row, glyph bit and in-cell flag v0 (same condition as vram_rd).
// - S1 (edge 2):
//   - font_addr <= {vram_data, glyph_row}.
//   - v1 <= v0; bit select and cursor-match flag carried.
// - S2 (edge 3):
//   - rgb <= v2 ? (font_data[bit] ^ cur ? FG : BG) : 3'b000.
//   - active_o, hsync_o and vsync_o aligned with rgb.
// - Latency: rgb reflects px_x/px_y presented 3 clk earlier; throughput 1 pixel/clk, no stalls.
// - Outside visible area or past last text row:
//   - vram_rd=0, rgb=3'b000, font_addr holds its last value.
// - Reset values: vram_rd=0, vram_addr=0, font_addr=0, rgb=0, hsync_o=1, vsync_o=1, active_o=0.
//   All pipeline valid bits are cleared.
// - Reset mid-frame: the pipeline flushes and rgb=0 until 3 clk after reset deasserts.
//   No partial pixel leaks out.
// - cursor_x >= cols or cursor_y >= rows_max: no cell matches, no cursor drawn.
// CONFIGURATION
// - CURSOR_BLINK_EN defined:
//   - 5-bit frame counter increments on each vsync_i 1->0 edge; reset to 0.
//   - cur = (col==cursor_x && row==cursor_y && counter[4]==0).
//   - The matched cell is drawn inverted for 16 frames, then normal for 16 frames.
// - CURSOR_BLINK_EN undefined: cur = 0, frame counter not built, cursor inputs unused.
// TESTING
// - size=8, VRAM[0]=8'h41, font[{41,0}]=8'h18:
//   - px(3,0) active -> vram_addr=0; font_addr=11'h208; rgb=FG at clk+3.
//   - px(0,0) -> rgb=BG.
// - size=16, px(33,17) active -> vram_addr=42 (row1*40+col2), vram_rd=1, glyph row 0, bit 7.
// - size=16, px(100,496) active (row 31 >= 31) -> vram_rd=0, rgb=000 at clk+3.
// - Sweep: active_i=0 for any px, and px_x=640 -> rgb=000.
//   - hsync_o/vsync_o equal hsync_i/vsync_i delayed exactly 3 clk.
// - Reset pulse 1 clk mid-line -> rgb=000 for 3 clk after release, then correct pixels resume.
// - CURSOR_BLINK_EN, cursor=(2,1), size=16, font bit=0 at px(33,17):
//   - frames 0-15 -> rgb=FG; frames 16-31 -> rgb=BG.

Source files
------------

// File: rtl/text_scanout_if.sv
// Memory-side read bus of the text scanout: VRAM character fetch and font ROM glyph fetch.
interface text_scanout_if;
    localparam int unsigned VRAM_AW = 13;
    localparam int unsigned FONT_AW = 11;
    localparam int unsigned DW      = 8;

    logic               vram_rd;
    logic [VRAM_AW-1:0] vram_addr;
    logic [DW-1:0]      vram_data;
    logic [FONT_AW-1:0] font_addr;
    logic [DW-1:0]      font_data;

    modport master (output vram_rd, vram_addr, font_addr, input vram_data, font_data);
    modport slave  (input vram_rd, vram_addr, font_addr, output vram_data, font_data);
endinterface

// File: rtl/text_scanout.sv
// Text-mode scanout: 3-stage pixel pipeline VRAM -> font ROM -> RGB, syncs delayed to match.
// Optional blinking cursor when CURSOR_BLINK_EN is defined.
module text_scanout #(
    parameter int unsigned size = 16,
    parameter logic [2:0]  FG   = 3'b111,
    parameter logic [2:0]  BG   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] px_x,
    input  logic [9:0] px_y,
    input  logic       active_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic [6:0] cursor_x,
    input  logic [6:0] cursor_y,
    text_scanout_if.master mem,
    output logic [2:0] rgb,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       active_o
);
    localparam int unsigned LG   = $clog2(size);
    localparam int unsigned SH   = LG - 3;
    localparam int unsigned COLS = 640 / size;

    // Last usable text row depends on cell size (page end + 1).
    function automatic int unsigned rows_of(input int unsigned s);
        case (s)
            8:       return 52;
            16:      return 31;
            32:      return 16;
            64:      return 8;
            128:     return 4;
            default: return 2;
        endcase
    endfunction
    localparam int unsigned ROWS_MAX = rows_of(size);

    logic [9:0]  col_c, row_c;
    logic        in_cell_c, cur_match_c, blink_on_c;

    logic        vram_rd_q, vram_rd_d;
    logic [12:0] vram_addr_q, vram_addr_d;
    logic [2:0]  grow0_q, grow0_d;
    logic [2:0]  gbit0_q, gbit0_d;
    logic        cur0_q, cur0_d;
    logic [10:0] font_addr_q, font_addr_d;
    logic        v1_q, v1_d;
    logic [2:0]  gbit1_q, gbit1_d;
    logic        cur1_q, cur1_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [2:0]  hs_q, hs_d;
    logic [2:0]  vs_q, vs_d;
    logic [2:0]  act_q, act_d;

    assign col_c       = 10'(px_x >> LG);
    assign row_c       = 10'(px_y >> LG);
    assign in_cell_c   = active_i && (px_x < 10'd640) && (row_c < 10'(ROWS_MAX));
    assign cur_match_c = (col_c == 10'(cursor_x)) && (row_c == 10'(cursor_y));

`ifdef CURSOR_BLINK_EN
    logic [4:0] frame_q, frame_d;
    logic       vs_prev_q, vs_prev_d;

    // Frame counter advances on each vsync falling edge; bit 4 selects the blink phase.
    always_comb begin
        vs_prev_d = vsync_i;
        frame_d   = frame_q;
        if (vs_prev_q && !vsync_i) frame_d = frame_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q   <= 5'd0;
            vs_prev_q <= 1'b1;
        end else begin
            frame_q   <= frame_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign blink_on_c = ~frame_q[4];
`else
    assign blink_on_c = 1'b0;
`endif

    // Pipeline next-state: S0 address/glyph position, S1 font fetch, S2 colour.
    always_comb begin
        vram_rd_d   = in_cell_c;
        vram_addr_d = 13'(row_c) * 13'(COLS) + 13'(col_c);
        grow0_d     = 3'(px_y >> SH);
        gbit0_d     = 3'd7 - 3'(px_x >> SH);
        cur0_d      = in_cell_c && cur_match_c && blink_on_c;

        font_addr_d = font_addr_q;
        if (vram_rd_q) font_addr_d = {mem.vram_data, grow0_q};
        v1_d        = vram_rd_q;
        gbit1_d     = gbit0_q;
        cur1_d      = cur0_q;

        rgb_d = 3'b000;
        if (v1_q) rgb_d = (mem.font_data[gbit1_q] ^ cur1_q) ? FG : BG;

        hs_d  = {hs_q[1:0], hsync_i};
        vs_d  = {vs_q[1:0], vsync_i};
        act_d = {act_q[1:0], active_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vram_rd_q   <= 1'b0;
            vram_addr_q <= 13'd0;
            grow0_q     <= 3'd0;
            gbit0_q     <= 3'd0;
            cur0_q      <= 1'b0;
            font_addr_q <= 11'd0;
            v1_q        <= 1'b0;
            gbit1_q     <= 3'd0;
            cur1_q      <= 1'b0;
            rgb_q       <= 3'b000;
            hs_q        <= 3'b111;
            vs_q        <= 3'b111;
            act_q       <= 3'b000;
        end else begin
            vram_rd_q   <= vram_rd_d;
            vram_addr_q <= vram_addr_d;
            grow0_q     <= grow0_d;
            gbit0_q     <= gbit0_d;
            cur0_q      <= cur0_d;
            font_addr_q <= font_addr_d;
            v1_q        <= v1_d;
            gbit1_q     <= gbit1_d;
            cur1_q      <= cur1_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            act_q       <= act_d;
        end
    end

    assign mem.vram_rd   = vram_rd_q;
    assign mem.vram_addr = vram_addr_q;
    assign mem.font_addr = font_addr_q;
    assign rgb           = rgb_q;
    assign hsync_o       = hs_q[2];
    assign vsync_o       = vs_q[2];
    assign active_o      = act_q[2];
endmodule

// File: tb/tb_text_scanout.sv
// Scoreboard bench for text_scanout (size=16): directed pixels, sync sweep, reset flush, cursor.
module tb_text_scanout;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;
`ifdef CURSOR_BLINK_EN
    localparam logic [2:0] CUR0 = FG;
`else
    localparam logic [2:0] CUR0 = BG;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] px_x = 10'd6, px_y = 10'd0;
    logic       active_i = 1'b1, hsync_i = 1'b1, vsync_i = 1'b1;
    logic [6:0] cursor_x = 7'd40, cursor_y = 7'd0;
    logic [2:0] rgb;
    logic       hsync_o, vsync_o, active_o;

    logic [7:0] vram [8192];
    logic [7:0] font [2048];

    text_scanout_if mem_if();

    text_scanout dut (
        .clk(clk), .reset(reset), .px_x(px_x), .px_y(px_y),
        .active_i(active_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .mem(mem_if),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o)
    );

    always #5 clk = ~clk;

    assign mem_if.vram_data = mem_if.vram_rd ? vram[mem_if.vram_addr] : 8'h00;
    assign mem_if.font_data = font[mem_if.font_addr];

    typedef struct {
        int          issue;
        logic [2:0]  rgb;
        logic        hs, vs, act, rd, chk_a, chk_f;
        logic [12:0] addr;
        logic [10:0] faddr;
    } exp_t;

    exp_t q_s0[$], q_s1[$], q_out[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, want);
        end
    endtask

    task automatic drive(input int x, input int y, input logic act, input logic hs, input logic vs,
                         input logic rd, input logic chk_a, input int addr,
                         input logic chk_f, input int faddr, input logic [2:0] rgb_e);
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b0;
        px_x = 10'(x); px_y = 10'(y); active_i = act; hsync_i = hs; vsync_i = vs;
        e.issue = cyc; e.rgb = rgb_e; e.hs = hs; e.vs = vs; e.act = act;
        e.rd = rd; e.chk_a = chk_a; e.addr = 13'(addr); e.chk_f = chk_f; e.faddr = 11'(faddr);
        q_s0.push_back(e);
        if (chk_f) q_s1.push_back(e);
        q_out.push_back(e);
    endtask

    // One-clock reset pulse in the middle of a line; in-flight pixels become reset values.
    task automatic reset_pulse();
        exp_t r;
        int   t;
        drive(6, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, FG);
        reset = 1'b1;
        t = cyc;
        void'(q_s0.pop_back());
        while (q_s1.size() > 0 && q_s1[$].issue >= t - 1) void'(q_s1.pop_back());
        while (q_out.size() > 0 && q_out[$].issue >= t - 2) void'(q_out.pop_back());
        r.rgb = 3'b000; r.hs = 1'b1; r.vs = 1'b1; r.act = 1'b0; r.rd = 1'b0;
        r.chk_a = 1'b1; r.addr = 13'd0; r.chk_f = 1'b0; r.faddr = 11'd0;
        r.issue = t;
        q_s0.push_back(r);
        for (int k = 2; k >= 0; k--) begin
            r.issue = t - k;
            q_out.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        if (q_s0.size() > 0 && q_s0[0].issue + 1 == cyc) begin
            m_e = q_s0.pop_front();
            check("vram_rd", 32'(mem_if.vram_rd), 32'(m_e.rd));
            if (m_e.chk_a) check("vram_addr", 32'(mem_if.vram_addr), 32'(m_e.addr));
        end
        if (q_s1.size() > 0 && q_s1[0].issue + 2 == cyc) begin
            m_e = q_s1.pop_front();
            check("font_addr", 32'(mem_if.font_addr), 32'(m_e.faddr));
        end
        if (q_out.size() > 0 && q_out[0].issue + 3 == cyc) begin
            m_e = q_out.pop_front();
            check("rgb", 32'(rgb), 32'(m_e.rgb));
            check("hsync_o", 32'(hsync_o), 32'(m_e.hs));
            check("vsync_o", 32'(vsync_o), 32'(m_e.vs));
            check("active_o", 32'(active_o), 32'(m_e.act));
        end
    end

    initial begin
        logic [7:0] hp, vp;
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        for (int i = 0; i < 2048; i++) font[i] = 8'h00;
        vram[0]    = 8'h41;
        vram[39]   = 8'h42;
        vram[40]   = 8'h41;
        vram[42]   = 8'h42;
        vram[1200] = 8'h41;
        font[11'h208] = 8'h18;
        font[11'h20B] = 8'h3C;
        font[11'h210] = 8'h01;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_vram_rd", 32'(mem_if.vram_rd), 32'd0);
        check("rst_vram_addr", 32'(mem_if.vram_addr), 32'd0);
        check("rst_font_addr", 32'(mem_if.font_addr), 32'd0);
        check("rst_hsync_o", 32'(hsync_o), 32'd1);
        check("rst_vsync_o", 32'(vsync_o), 32'd1);
        check("rst_active_o", 32'(active_o), 32'd0);

        // Cursor cell (2,1): glyph bit 7 of 0x01 is 0, inverted only while blink phase is on.
        cursor_x = 7'd2; cursor_y = 7'd1;
        drive(33, 17, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 42, 1'b1, 'h210, CUR0);
        for (int f = 0; f < 16; f++) begin
            drive(700, 500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 3'b000);
            drive(700, 500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 3'b000);
        end
        drive(33, 17, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 42, 1'b1, 'h210, BG);
        cursor_x = 7'd40; cursor_y = 7'd0;

        // Directed pixels: x, y, act, hs, vs, rd, chk_a, addr, chk_f, faddr, rgb
        drive(6,   0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0,    1'b1, 'h208, FG);
        drive(0,   0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0,    1'b1, 'h208, BG);
        drive(8,   0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0,    1'b0, 0,     FG);
        drive(46,  17,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 42,   1'b1, 'h210, FG);
        drive(6,   22,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 40,   1'b1, 'h20B, FG);
        drive(2,   22,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 40,   1'b1, 'h20B, BG);
        drive(6,   480, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1200, 1'b1, 'h208, FG);
        drive(639, 0,   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 39,   1'b1, 'h210, FG);
        drive(100, 496, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,    1'b0, 0,     3'b000);
        drive(640, 0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,    1'b0, 0,     3'b000);
        drive(700, 10,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,    1'b0, 0,     3'b000);
        drive(6,   0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0,    1'b0, 0,     3'b000);

        // Inactive sweep with varying syncs: only the 3-clk sync delay is visible.
        hp = 8'b1100_1010;
        vp = 8'b0111_0001;
        for (int i = 0; i < 8; i++)
            drive(6 + i, 0, 1'b0, hp[i], vp[i], 1'b0, 1'b0, 0, 1'b0, 0, 3'b000);

        // Mid-line reset: FG pixels before and after, three reset-valued outputs in between.
        for (int i = 0; i < 4; i++)
            drive(6, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, FG);
        reset_pulse();
        for (int i = 0; i < 5; i++)
            drive(6, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, FG);

        for (int i = 0; i < 20 && (q_s0.size() + q_s1.size() + q_out.size()) > 0; i++)
            @(negedge clk);
        #2;
        if ((q_s0.size() + q_s1.size() + q_out.size()) > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected responses never observed, required 0",
                     q_s0.size() + q_s1.size() + q_out.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
